// File: rtl/instruction_decode_pkg.sv
// Shared constants for the instruction decode stage: opcodes, op classes, exception codes
// and the decoded bundle type.
package instruction_decode_pkg;

    localparam int unsigned EXCEPTION_LEN = 4;

    localparam logic [EXCEPTION_LEN-1:0] EXC_NONE          = EXCEPTION_LEN'(0);
    localparam logic [EXCEPTION_LEN-1:0] EXC_ILLEGAL_INSTR = EXCEPTION_LEN'(2);
    localparam logic [EXCEPTION_LEN-1:0] EXC_BREAKPOINT    = EXCEPTION_LEN'(3);
    localparam logic [EXCEPTION_LEN-1:0] EXC_ECALL         = EXCEPTION_LEN'(11);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0]  F7_BASE      = 7'b0000000;
    localparam logic [6:0]  F7_ALT       = 7'b0100000;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        OcLui    = 4'd0,
        OcAuipc  = 4'd1,
        OcJal    = 4'd2,
        OcJalr   = 4'd3,
        OcBranch = 4'd4,
        OcLoad   = 4'd5,
        OcStore  = 4'd6,
        OcOpImm  = 4'd7,
        OcOp     = 4'd8,
        OcFence  = 4'd9,
        OcSystem = 4'd10
    } op_class_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt_op;
        logic [31:0] imm;
        op_class_e   op_class;
        logic        rd_write;
    } decode_t;

    // ADDI x0,x0,0 presented whenever no bundle is valid.
    localparam decode_t IdleBundle = '{
        pc:       32'h0,
        rd:       5'd0,
        rs1:      5'd0,
        rs2:      5'd0,
        funct3:   3'd0,
        alt_op:   1'b0,
        imm:      32'h0,
        op_class: OcOpImm,
        rd_write: 1'b0
    };

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
interface instruction_decode_if #(
    parameter int unsigned EXCEPTION_LEN = instruction_decode_pkg::EXCEPTION_LEN
) ();

    logic [31:0]              instr_In;
    logic [31:0]              pc_In;
    logic [EXCEPTION_LEN-1:0] exception_In;
    logic                     valid_In;
    logic                     ready_Out;
    logic                     flush_In;
    logic                     valid_Out;
    logic                     ready_In;
    logic [31:0]              pc_Out;
    logic [4:0]               rd_Out;
    logic [4:0]               rs1_Out;
    logic [4:0]               rs2_Out;
    logic [2:0]               funct3_Out;
    logic                     altOp_Out;
    logic [31:0]              imm_Out;
    logic [3:0]               opClass_Out;
    logic                     rdWrite_Out;
    logic [EXCEPTION_LEN-1:0] exception_Out;

    modport master (
        output instr_In, pc_In, exception_In, valid_In, flush_In, ready_In,
        input  ready_Out, valid_Out, pc_Out, rd_Out, rs1_Out, rs2_Out, funct3_Out,
               altOp_Out, imm_Out, opClass_Out, rdWrite_Out, exception_Out
    );

    modport slave (
        input  instr_In, pc_In, exception_In, valid_In, flush_In, ready_In,
        output ready_Out, valid_Out, pc_Out, rd_Out, rs1_Out, rs2_Out, funct3_Out,
               altOp_Out, imm_Out, opClass_Out, rdWrite_Out, exception_Out
    );

endinterface

// File: rtl/instruction_decode_decode_logic.sv
// Combinational RV32I decoder: field extraction, immediate generation, legality and
// exception prioritisation.
module decode_logic
    import instruction_decode_pkg::*;
#(
    parameter int unsigned EXCEPTION_LEN = instruction_decode_pkg::EXCEPTION_LEN
) (
    input  logic [31:0]              instr_i,
    input  logic [31:0]              pc_i,
    input  logic [EXCEPTION_LEN-1:0] exception_i,
    output decode_t                  dec_o,
    output logic [EXCEPTION_LEN-1:0] exception_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm;
    logic        illegal, is_ecall, is_ebreak, wr_class;
    op_class_e   op_class;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

    always_comb begin
        op_class  = OcOpImm;
        imm       = 32'h0;
        wr_class  = 1'b0;
        illegal   = 1'b0;
        is_ecall  = 1'b0;
        is_ebreak = 1'b0;
        case (opcode)
            OPC_LUI: begin
                op_class = OcLui;
                imm      = imm_u;
                wr_class = 1'b1;
            end
            OPC_AUIPC: begin
                op_class = OcAuipc;
                imm      = imm_u;
                wr_class = 1'b1;
            end
            OPC_JAL: begin
                op_class = OcJal;
                imm      = imm_j;
                wr_class = 1'b1;
            end
            OPC_JALR: begin
                op_class = OcJalr;
                imm      = imm_i;
                wr_class = 1'b1;
                illegal  = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                op_class = OcBranch;
                imm      = imm_b;
                illegal  = funct3 inside {3'b010, 3'b011};
            end
            OPC_LOAD: begin
                op_class = OcLoad;
                imm      = imm_i;
                wr_class = 1'b1;
                illegal  = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                op_class = OcStore;
                imm      = imm_s;
                illegal  = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                op_class = OcOpImm;
                imm      = imm_i;
                wr_class = 1'b1;
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    illegal = !(funct7 inside {F7_BASE, F7_ALT});
                end
            end
            OPC_OP: begin
                op_class = OcOp;
                wr_class = 1'b1;
                if (funct7 == F7_ALT) begin
                    illegal = !(funct3 inside {3'b000, 3'b101});
                end else begin
                    illegal = (funct7 != F7_BASE);
                end
            end
            OPC_FENCE: begin
                op_class = OcFence;
            end
            OPC_SYSTEM: begin
                op_class  = OcSystem;
                is_ecall  = (instr_i == INSTR_ECALL);
                is_ebreak = (instr_i == INSTR_EBREAK);
                illegal   = !(is_ecall || is_ebreak);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Fetch-side faults outrank anything found in the instruction bits.
    always_comb begin
        if (exception_i != '0) begin
            exception_o = exception_i;
        end else if (illegal) begin
            exception_o = EXCEPTION_LEN'(EXC_ILLEGAL_INSTR);
        end else if (is_ecall) begin
            exception_o = EXCEPTION_LEN'(EXC_ECALL);
        end else if (is_ebreak) begin
            exception_o = EXCEPTION_LEN'(EXC_BREAKPOINT);
        end else begin
            exception_o = EXCEPTION_LEN'(EXC_NONE);
        end
    end

    always_comb begin
        dec_o          = IdleBundle;
        dec_o.pc       = pc_i;
        dec_o.rd       = instr_i[11:7];
        dec_o.rs1      = instr_i[19:15];
        dec_o.rs2      = instr_i[24:20];
        dec_o.funct3   = funct3;
        dec_o.alt_op   = ((op_class == OcOp) || (op_class == OcOpImm && funct3 == 3'b101))
                         ? instr_i[30] : 1'b0;
        dec_o.imm      = imm;
        dec_o.op_class = op_class;
        dec_o.rd_write = wr_class && (instr_i[11:7] != 5'd0) &&
                         (exception_o == EXCEPTION_LEN'(EXC_NONE));
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: one decoder in front of a 1-deep output register plus a skid entry, giving
// single-cycle latency and full throughput with a registered ready.
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int unsigned EXCEPTION_LEN = instruction_decode_pkg::EXCEPTION_LEN
) (
    input logic                 clk,
    input logic                 rst,
    instruction_decode_if.slave bus
);

    decode_t                  new_dec;
    logic [EXCEPTION_LEN-1:0] new_exc;

    decode_t                  out_q, out_d, skid_q, skid_d, disp;
    logic [EXCEPTION_LEN-1:0] out_exc_q, out_exc_d, skid_exc_q, skid_exc_d, disp_exc;
    logic                     out_valid_q, out_valid_d;
    logic                     skid_valid_q, skid_valid_d;
    logic                     ready_q, ready_d;
    logic                     accept;

    decode_logic #(
        .EXCEPTION_LEN(EXCEPTION_LEN)
    ) u_decode (
        .instr_i    (bus.instr_In),
        .pc_i       (bus.pc_In),
        .exception_i(bus.exception_In),
        .dec_o      (new_dec),
        .exception_o(new_exc)
    );

    assign accept = bus.valid_In && ready_q;

    always_comb begin
        out_d        = out_q;
        out_exc_d    = out_exc_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_exc_d   = skid_exc_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush_In) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.ready_In) begin
            // Output slot frees up: the skid entry is older than anything arriving now.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_exc_d    = skid_exc_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_d       = new_dec;
                out_exc_d   = new_exc;
                out_valid_d = accept;
            end
        end else if (accept) begin
            skid_d       = new_dec;
            skid_exc_d   = new_exc;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q        <= IdleBundle;
            out_exc_q    <= EXCEPTION_LEN'(EXC_NONE);
            out_valid_q  <= 1'b0;
            skid_q       <= IdleBundle;
            skid_exc_q   <= EXCEPTION_LEN'(EXC_NONE);
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_exc_q    <= out_exc_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_exc_q   <= skid_exc_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign disp     = out_valid_q ? out_q : IdleBundle;
    assign disp_exc = out_valid_q ? out_exc_q : EXCEPTION_LEN'(EXC_NONE);

    assign bus.ready_Out     = ready_q;
    assign bus.valid_Out     = out_valid_q;
    assign bus.pc_Out        = disp.pc;
    assign bus.rd_Out        = disp.rd;
    assign bus.rs1_Out       = disp.rs1;
    assign bus.rs2_Out       = disp.rs2;
    assign bus.funct3_Out    = disp.funct3;
    assign bus.altOp_Out     = disp.alt_op;
    assign bus.imm_Out       = disp.imm;
    assign bus.opClass_Out   = disp.op_class;
    assign bus.rdWrite_Out   = disp.rd_write;
    assign bus.exception_Out = disp_exc;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode vector table plus stall, flush and reset
// sequences.
module tb_instruction_decode;
    import instruction_decode_pkg::*;

    typedef struct {
        logic [31:0]              instr;
        logic [EXCEPTION_LEN-1:0] exc_in;
        logic                     chk_class;
        op_class_e                cls;
        logic [4:0]               rd;
        logic [4:0]               rs1;
        logic [2:0]               f3;
        logic                     alt;
        logic [31:0]              imm;
        logic                     rdw;
        logic [EXCEPTION_LEN-1:0] exc;
    } vec_t;

    localparam int NVEC = 19;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t vecs[NVEC];

    instruction_decode_if #(.EXCEPTION_LEN(EXCEPTION_LEN)) bus_if ();

    instruction_decode #(
        .EXCEPTION_LEN(EXCEPTION_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [EXCEPTION_LEN-1:0] exc);
        bus_if.instr_In     = instr;
        bus_if.pc_In        = pc;
        bus_if.exception_In = exc;
        bus_if.valid_In     = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".valid"}, 32'(bus_if.valid_Out), 32'd0);
        chk({tag, ".ready"}, 32'(bus_if.ready_Out), 32'd1);
        chk({tag, ".pc"}, bus_if.pc_Out, 32'h0);
        chk({tag, ".class"}, 32'(bus_if.opClass_Out), 32'(OcOpImm));
        chk({tag, ".regs"}, {17'd0, bus_if.rd_Out, bus_if.rs1_Out, bus_if.rs2_Out},
            32'd0);
        chk({tag, ".f3alt"}, {28'd0, bus_if.funct3_Out, bus_if.altOp_Out}, 32'd0);
        chk({tag, ".imm"}, bus_if.imm_Out, 32'h0);
        chk({tag, ".rdw"}, 32'(bus_if.rdWrite_Out), 32'd0);
        chk({tag, ".exc"}, 32'(bus_if.exception_Out), 32'(EXC_NONE));
    endtask

    task automatic check_vec(input int i, input logic [31:0] pc);
        string t;
        t = $sformatf("v%0d", i);
        chk({t, ".valid"}, 32'(bus_if.valid_Out), 32'd1);
        chk({t, ".pc"}, bus_if.pc_Out, pc);
        if (vecs[i].chk_class) chk({t, ".class"}, 32'(bus_if.opClass_Out), 32'(vecs[i].cls));
        chk({t, ".rd"}, 32'(bus_if.rd_Out), 32'(vecs[i].rd));
        chk({t, ".rs1"}, 32'(bus_if.rs1_Out), 32'(vecs[i].rs1));
        chk({t, ".f3"}, 32'(bus_if.funct3_Out), 32'(vecs[i].f3));
        chk({t, ".alt"}, 32'(bus_if.altOp_Out), 32'(vecs[i].alt));
        chk({t, ".imm"}, bus_if.imm_Out, vecs[i].imm);
        chk({t, ".rdw"}, 32'(bus_if.rdWrite_Out), 32'(vecs[i].rdw));
        chk({t, ".exc"}, 32'(bus_if.exception_Out), 32'(vecs[i].exc));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //            instr        excin cc class     rd  rs1 f3 alt imm           rdw exc
        vecs[0]  = '{32'h00500093, 4'd0, 1, OcOpImm,  1,  0,  0, 0, 32'h00000005, 1, EXC_NONE};
        vecs[1]  = '{32'hFE000EE3, 4'd0, 1, OcBranch, 29, 0,  0, 0, 32'hFFFFFFFC, 0, EXC_NONE};
        vecs[2]  = '{32'h123452B7, 4'd0, 1, OcLui,    5,  8,  5, 0, 32'h12345000, 1, EXC_NONE};
        vecs[3]  = '{32'h00000000, 4'd0, 0, OcOpImm,  0,  0,  0, 0, 32'h00000000, 0,
                     EXC_ILLEGAL_INSTR};
        vecs[4]  = '{32'h00000073, 4'd5, 1, OcSystem, 0,  0,  0, 0, 32'h00000000, 0, 4'd5};
        vecs[5]  = '{32'h00000073, 4'd0, 1, OcSystem, 0,  0,  0, 0, 32'h00000000, 0, EXC_ECALL};
        vecs[6]  = '{32'h00100073, 4'd0, 1, OcSystem, 0,  0,  0, 0, 32'h00000000, 0,
                     EXC_BREAKPOINT};
        vecs[7]  = '{32'h402081B3, 4'd0, 1, OcOp,     3,  1,  0, 1, 32'h00000000, 1, EXC_NONE};
        vecs[8]  = '{32'h402091B3, 4'd0, 1, OcOp,     3,  1,  1, 1, 32'h00000000, 0,
                     EXC_ILLEGAL_INSTR};
        vecs[9]  = '{32'h000090E7, 4'd0, 1, OcJalr,   1,  1,  1, 0, 32'h00000000, 0,
                     EXC_ILLEGAL_INSTR};
        vecs[10] = '{32'hFF812283, 4'd0, 1, OcLoad,   5,  2,  2, 0, 32'hFFFFFFF8, 1, EXC_NONE};
        vecs[11] = '{32'h00612623, 4'd0, 1, OcStore,  12, 2,  2, 0, 32'h0000000C, 0, EXC_NONE};
        vecs[12] = '{32'hFF1FF0EF, 4'd0, 1, OcJal,    1,  31, 7, 0, 32'hFFFFFFF0, 1, EXC_NONE};
        vecs[13] = '{32'h00100013, 4'd0, 1, OcOpImm,  0,  0,  0, 0, 32'h00000001, 0, EXC_NONE};
        vecs[14] = '{32'h4030D093, 4'd0, 1, OcOpImm,  1,  1,  5, 1, 32'h00000403, 1, EXC_NONE};
        vecs[15] = '{32'h40309093, 4'd0, 1, OcOpImm,  1,  1,  1, 0, 32'h00000403, 0,
                     EXC_ILLEGAL_INSTR};
        vecs[16] = '{32'h0FF0000F, 4'd0, 1, OcFence,  0,  0,  0, 0, 32'h00000000, 0, EXC_NONE};
        vecs[17] = '{32'hFFFFF117, 4'd0, 1, OcAuipc,  2,  31, 7, 0, 32'hFFFFF000, 1, EXC_NONE};
        vecs[18] = '{32'h00500090, 4'd0, 0, OcOpImm,  1,  0,  0, 0, 32'h00000000, 0,
                     EXC_ILLEGAL_INSTR};

        rst                 = 1'b0;
        bus_if.instr_In     = 32'h0;
        bus_if.pc_In        = 32'h0;
        bus_if.exception_In = '0;
        bus_if.valid_In     = 1'b0;
        bus_if.flush_In     = 1'b0;
        bus_if.ready_In     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_idle("reset");

        // Streaming table at full throughput.
        bus_if.ready_In = 1'b1;
        drive(vecs[0].instr, 32'h100, vecs[0].exc_in);
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            check_vec(i, 32'h100 + 32'(i) * 32'd4);
            chk($sformatf("v%0d.ready", i), 32'(bus_if.ready_Out), 32'd1);
            if (i + 1 < NVEC) begin
                drive(vecs[i+1].instr, 32'h100 + 32'(i + 1) * 32'd4, vecs[i+1].exc_in);
            end else begin
                bus_if.valid_In = 1'b0;
            end
        end
        @(negedge clk);
        chk("drain.valid", 32'(bus_if.valid_Out), 32'd0);

        // A, B, C back to back with downstream stalled for three edges.
        bus_if.ready_In = 1'b0;
        drive(32'h00500093, 32'h200, '0);
        @(negedge clk);
        chk("abc.a_valid", 32'(bus_if.valid_Out), 32'd1);
        chk("abc.a_pc", bus_if.pc_Out, 32'h200);
        chk("abc.ready1", 32'(bus_if.ready_Out), 32'd1);
        drive(32'h123452B7, 32'h204, '0);
        @(negedge clk);
        chk("abc.a_hold1", bus_if.pc_Out, 32'h200);
        chk("abc.ready_fall", 32'(bus_if.ready_Out), 32'd0);
        drive(32'h402081B3, 32'h208, '0);
        @(negedge clk);
        chk("abc.a_hold2", bus_if.pc_Out, 32'h200);
        chk("abc.a_imm", bus_if.imm_Out, 32'h5);
        chk("abc.c_stall", 32'(bus_if.ready_Out), 32'd0);
        bus_if.ready_In = 1'b1;
        @(negedge clk);
        chk("abc.b_valid", 32'(bus_if.valid_Out), 32'd1);
        chk("abc.b_pc", bus_if.pc_Out, 32'h204);
        chk("abc.b_rd", 32'(bus_if.rd_Out), 32'd5);
        chk("abc.ready_rise", 32'(bus_if.ready_Out), 32'd1);
        @(negedge clk);
        chk("abc.c_pc", bus_if.pc_Out, 32'h208);
        chk("abc.c_class", 32'(bus_if.opClass_Out), 32'(OcOp));
        bus_if.valid_In = 1'b0;
        @(negedge clk);
        chk("abc.empty", 32'(bus_if.valid_Out), 32'd0);

        // Flush with both entries full and a new instruction offered.
        bus_if.ready_In = 1'b0;
        drive(32'h00500093, 32'h300, '0);
        @(negedge clk);
        drive(32'h123452B7, 32'h304, '0);
        @(negedge clk);
        chk("flush.full", 32'(bus_if.ready_Out), 32'd0);
        drive(32'h402081B3, 32'h308, '0);
        bus_if.flush_In = 1'b1;
        @(negedge clk);
        check_idle("flush");
        bus_if.flush_In = 1'b0;
        bus_if.valid_In = 1'b0;
        bus_if.ready_In = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("flush.stale%0d", k), 32'(bus_if.valid_Out), 32'd0);
        end

        // One-cycle reset while the skid entry is full.
        bus_if.ready_In = 1'b0;
        drive(32'h00500093, 32'h400, '0);
        @(negedge clk);
        drive(32'h123452B7, 32'h404, '0);
        @(negedge clk);
        chk("rst.full", 32'(bus_if.ready_Out), 32'd0);
        bus_if.valid_In = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_idle("rst");
        bus_if.ready_In = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst.stale%0d", k), 32'(bus_if.valid_Out), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
